// File: rtl/wb_regfile.sv
// Write-back stage: selects load/ALU result, commits it to a 32-entry register file
// and tracks program termination (RUN -> DRAIN -> HALTED). Optional macro: RF_BYPASS_EN.
module wb_regfile #(
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_in,
  input  logic              mem_r_in,
  input  logic [DATA_W-1:0] mem_result_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [4:0]        reg_dest_in,
  input  logic              terminate_in,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_en_out,
  output logic [4:0]        wb_dest_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              halted,
  output logic [31:0]       retired_count,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_drain_cnt;
  logic              r_halted;
  logic [31:0]       r_retired;
  logic [DATA_W-1:0] r_regs [32];
  logic              w_run;

  // State register; halted is registered off the next state so it rises on the entering edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_halted <= (w_next_state == S_HALTED);
      if (r_state == S_RUN && terminate_in)
        r_drain_cnt <= 4'(DRAIN_CYCLES);
      else if (r_state == S_DRAIN && r_drain_cnt != 4'd0)
        r_drain_cnt <= r_drain_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN:    if (terminate_in) w_next_state = S_DRAIN;
      S_DRAIN:  if (r_drain_cnt == 4'd0) w_next_state = S_HALTED;
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_RUN;
    endcase
  end

  always_comb begin
    w_run       = (r_state == S_RUN);
    wb_en_out   = wb_in && (reg_dest_in != 5'd0) && w_run;
    wb_data_out = mem_r_in ? mem_result_in : alu_result_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (wb_en_out) begin
      r_regs[reg_dest_in] <= wb_data_out;
    end
  end

  // Saturating count of committed writes.
  always_ff @(posedge clk) begin
    if (rst)
      r_retired <= '0;
    else if (wb_en_out && r_retired != 32'hFFFF_FFFF)
      r_retired <= r_retired + 32'd1;
  end

  // wb_en_out already implies a non-zero destination, so the bypass never touches address 0.
  always_comb begin
    rs_data = (rs_addr == 5'd0) ? '0 : r_regs[rs_addr];
    rt_data = (rt_addr == 5'd0) ? '0 : r_regs[rt_addr];
`ifdef RF_BYPASS_EN
    if (wb_en_out && rs_addr == reg_dest_in) rs_data = wb_data_out;
    if (wb_en_out && rt_addr == reg_dest_in) rt_data = wb_data_out;
`endif
  end

  assign wb_dest_out   = reg_dest_in;
  assign halted        = r_halted;
  assign retired_count = r_retired;
  assign o_dbg_state   = r_state;

endmodule
